act_feeder: RTL and testbench

- Activation source stage directly upstream of sblk_row.
- Latches an activation-tile instruction, waits for sblk_row's act_data_in_req, then reads n_tn*n_tp packed activation words from the activation buffer SRAM.
- Streams the words to sblk_row's act_data_in/act_data_in_vld, one per cycle, in n-outer / p-inner order.
- Pulses done when the last word has been delivered.

---
 rtl/act_feeder_if.sv | 29 ++
 rtl/act_feeder.sv | 145 ++++++++++++++
 tb/tb_act_feeder.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/act_feeder_if.sv
// Instruction, activation-SRAM read port and sblk_row streaming signals of act_feeder.
// The feeder itself connects through the slave modport.
interface act_feeder_if #(
   parameter int WID_ACT     = 16,
   parameter int WID_ACTADDR = 6,
   parameter int WID_INST_TN = 3,
   parameter int WID_INST_TP = 2
);
   logic [WID_ACTADDR+WID_INST_TP+WID_INST_TN-1:0] inst_data;
   logic                                           inst_en;
   logic                                           act_req;
   logic                                           act_mem_rd_en;
   logic [WID_ACTADDR-1:0]                         act_mem_rd_addr;
   logic [2*WID_ACT-1:0]                           act_mem_rd_data;
   logic                                           act_data_out_vld;
   logic [2*WID_ACT-1:0]                           act_data_out;
   logic                                           busy;
   logic                                           done;

   modport master (
      output inst_data, inst_en, act_req, act_mem_rd_data,
      input  act_mem_rd_en, act_mem_rd_addr, act_data_out_vld, act_data_out, busy, done
   );

   modport slave (
      input  inst_data, inst_en, act_req, act_mem_rd_data,
      output act_mem_rd_en, act_mem_rd_addr, act_data_out_vld, act_data_out, busy, done
   );
endinterface

// File: rtl/act_feeder.sv
// Activation source for sblk_row: latches a tile instruction, reads n_tn*n_tp packed
// words from the activation SRAM once requested, and streams them out in issue order.
module act_feeder #(
   parameter int WID_ACT     = 16,
   parameter int WID_ACTADDR = 6,
   parameter int WID_INST_TN = 3,
   parameter int WID_INST_TP = 2,
   parameter int RD_LAT      = 2
) (
   input  logic         clk_l,
   input  logic         rst_n,
   act_feeder_if.slave  bus
);
   localparam int WID_OFF = WID_INST_TN + WID_INST_TP;
   localparam logic [WID_INST_TN-1:0] TN_ONE = 1;
   localparam logic [WID_INST_TP-1:0] TP_ONE = 1;

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_STREAM, S_DRAIN} state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;

   logic [WID_ACTADDR-1:0]  r_base;
   logic [WID_INST_TP-1:0]  r_ntp;
   logic [WID_INST_TN-1:0]  r_ntn;
   logic [WID_INST_TN-1:0]  r_cnt_n;
   logic [WID_INST_TP-1:0]  r_cnt_p;
   logic [RD_LAT-1:0]       r_vpipe;
   logic                    r_vld;
   logic [2*WID_ACT-1:0]    r_data;

   logic [WID_ACTADDR-1:0]  w_inst_base;
   logic [WID_INST_TP-1:0]  w_inst_tp;
   logic [WID_INST_TN-1:0]  w_inst_tn;
   logic                    w_inst_empty;
   logic                    w_last_p;
   logic                    w_last;
   logic [WID_OFF-1:0]      w_off;
   logic [WID_ACTADDR-1:0]  w_addr;
   logic                    w_pipe_empty;
   logic                    w_accept;
   logic                    w_rd_en;
   logic                    w_busy;
   logic                    w_done;

   assign {w_inst_base, w_inst_tp, w_inst_tn} = bus.inst_data;
   assign w_inst_empty = (w_inst_tn == '0) || (w_inst_tp == '0);

   assign w_last_p = (r_cnt_p == r_ntp - TP_ONE);
   assign w_last   = w_last_p && (r_cnt_n == r_ntn - TN_ONE);

   // Offset fits WID_OFF bits (max (n_tn-1)*n_tp + n_tp-1); the address wraps modulo 2^WID_ACTADDR.
   assign w_off  = WID_OFF'(r_cnt_n) * WID_OFF'(r_ntp) + WID_OFF'(r_cnt_p);
   assign w_addr = r_base + WID_ACTADDR'(w_off);

   assign w_pipe_empty = (r_vpipe == '0) && !r_vld;

   always_ff @(posedge clk_l or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (bus.inst_en) w_state_nxt = w_inst_empty ? S_DRAIN : S_ARMED;
         S_ARMED:  if (bus.act_req) w_state_nxt = S_STREAM;
         S_STREAM: if (w_last) w_state_nxt = S_DRAIN;
         S_DRAIN:  if (w_pipe_empty) w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_accept = 1'b0;
      w_rd_en  = 1'b0;
      w_busy   = 1'b1;
      w_done   = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_accept = bus.inst_en;
            w_busy   = 1'b0;
         end
         S_STREAM: w_rd_en = 1'b1;
         S_DRAIN:  w_done  = w_pipe_empty;
         default: ;
      endcase
   end

   always_ff @(posedge clk_l or negedge rst_n) begin
      if (!rst_n) begin
         r_base  <= '0;
         r_ntp   <= '0;
         r_ntn   <= '0;
         r_cnt_n <= '0;
         r_cnt_p <= '0;
      end else begin
         if (w_accept) begin
            r_base <= w_inst_base;
            r_ntp  <= w_inst_tp;
            r_ntn  <= w_inst_tn;
         end
         if (r_state != S_STREAM) begin
            r_cnt_n <= '0;
            r_cnt_p <= '0;
         end else if (!w_last) begin
            if (w_last_p) begin
               r_cnt_p <= '0;
               r_cnt_n <= r_cnt_n + TN_ONE;
            end else begin
               r_cnt_p <= r_cnt_p + TP_ONE;
            end
         end
      end
   end

   // The valid shift register mirrors the SRAM latency; its tail marks the cycle rd_data is usable.
   always_ff @(posedge clk_l or negedge rst_n) begin
      if (!rst_n) begin
         r_vpipe <= '0;
         r_vld   <= 1'b0;
         r_data  <= '0;
      end else begin
         r_vpipe[0] <= w_rd_en;
         for (int unsigned i = 1; i < RD_LAT; i++) begin
            r_vpipe[i] <= r_vpipe[i-1];
         end
         r_vld <= r_vpipe[RD_LAT-1];
         if (r_vpipe[RD_LAT-1]) begin
            r_data <= bus.act_mem_rd_data;
         end
      end
   end

   assign bus.act_mem_rd_en    = w_rd_en;
   assign bus.act_mem_rd_addr  = w_rd_en ? w_addr : '0;
   assign bus.act_data_out_vld = r_vld;
   assign bus.act_data_out     = r_data;
   assign bus.busy             = w_busy;
   assign bus.done             = w_done;

endmodule

// File: tb/tb_act_feeder.sv
// Bench for act_feeder: three instances (RD_LAT 1..3) share one stimulus stream,
// each with its own activation SRAM model.
module tb_act_feeder;
   logic        clk_l;
   logic        rst_n;
   logic [10:0] inst_data;
   logic        inst_en;
   logic        act_req;

   logic        m_rd_en [3];
   logic [5:0]  m_addr  [3];
   logic        m_vld   [3];
   logic [31:0] m_data  [3];
   logic        m_busy  [3];
   logic        m_done  [3];

   int n_vec = 0;
   int n_err = 0;

   function automatic logic [31:0] mw(input logic [5:0] a);
      return {16'hA500 + {10'd0, a}, 16'h3C00 + {10'd0, a}};
   endfunction

   initial clk_l = 1'b0;
   always #5 clk_l = ~clk_l;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int L = g + 1;
      act_feeder_if #(.WID_ACT(16), .WID_ACTADDR(6), .WID_INST_TN(3), .WID_INST_TP(2)) bus ();
      logic [31:0] pipe [L];

      assign bus.inst_data = inst_data;
      assign bus.inst_en   = inst_en;
      assign bus.act_req   = act_req;

      always_ff @(posedge clk_l) begin
         pipe[0] <= bus.act_mem_rd_en ? mw(bus.act_mem_rd_addr) : 32'hDEAD_BEEF;
         for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
      end
      assign bus.act_mem_rd_data = pipe[L-1];

      act_feeder #(
         .WID_ACT(16), .WID_ACTADDR(6), .WID_INST_TN(3), .WID_INST_TP(2), .RD_LAT(L)
      ) u_dut (
         .clk_l (clk_l),
         .rst_n (rst_n),
         .bus   (bus.slave)
      );

      assign m_rd_en[g] = bus.act_mem_rd_en;
      assign m_addr[g]  = bus.act_mem_rd_addr;
      assign m_vld[g]   = bus.act_data_out_vld;
      assign m_data[g]  = bus.act_data_out;
      assign m_busy[g]  = bus.busy;
      assign m_done[g]  = bus.done;
   end

   typedef struct {
      logic        en;
      logic [10:0] inst;
      logic        req;
      logic        rd_en;
      logic [5:0]  addr;
      logic        vld;
      logic [31:0] data;
      logic        busy;
      logic        done;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic en, input logic [10:0] inst, input logic req,
                               input logic rd_en, input logic [5:0] addr, input logic vld,
                               input logic [31:0] data, input logic busy, input logic done);
      vec_t v;
      v.en = en; v.inst = inst; v.req = req; v.rd_en = rd_en; v.addr = addr;
      v.vld = vld; v.data = data; v.busy = busy; v.done = done;
      return v;
   endfunction

   function automatic logic [63:0] outs(input int i);
      return {22'd0, m_rd_en[i], m_addr[i], m_vld[i], m_data[i], m_busy[i], m_done[i]};
   endfunction

   task automatic chk(input string nm, input int i, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s [RD_LAT=%0d]: got %0h, want %0h", nm, i + 1, got, exp);
      end
   endtask

   // Generic burst: inst at c0, act_req high over [req_on,req_off) and from req_again on,
   // optional second inst pulse at inst2_at; every instance is checked.
   task automatic run_seq(input string nm, input logic [10:0] inst, input logic [5:0] base,
                          input int nwords, input int req_on, input int req_off,
                          input int req_again, input int inst2_at, input int ncyc);
      int nrd[3], nvl[3], ndn[3], rd0[3], vl0[3], vln[3], dnc[3], idc[3];
      logic [5:0] ea;
      for (int i = 0; i < 3; i++) begin
         nrd[i] = 0; nvl[i] = 0; ndn[i] = 0;
         rd0[i] = -1; vl0[i] = -1; vln[i] = -1; dnc[i] = -1; idc[i] = -1;
      end
      for (int c = 0; c < ncyc; c++) begin
         @(posedge clk_l); #1;
         inst_en   = (c == 0) || (c == inst2_at);
         inst_data = (c == 0) ? inst : 11'h0F9;
         act_req   = ((c >= req_on) && (c < req_off)) || (c >= req_again);
         @(negedge clk_l);
         for (int i = 0; i < 3; i++) begin
            if (m_rd_en[i]) begin
               if (rd0[i] < 0) rd0[i] = c;
               ea = base + 6'(nrd[i]);
               chk({nm, "_addr"}, i, 64'(m_addr[i]), 64'(ea));
               nrd[i]++;
            end
            if (m_vld[i]) begin
               if (vl0[i] < 0) vl0[i] = c;
               vln[i] = c;
               ea = base + 6'(nvl[i]);
               chk({nm, "_data"}, i, 64'(m_data[i]), 64'(mw(ea)));
               nvl[i]++;
            end
            if (m_done[i]) begin
               ndn[i]++;
               dnc[i] = c;
            end
            if (dnc[i] >= 0 && idc[i] < 0 && !m_busy[i]) idc[i] = c;
         end
      end
      inst_en = 1'b0;
      act_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk({nm, "_nrd"}, i, 64'(nrd[i]), 64'(nwords));
         chk({nm, "_nvld"}, i, 64'(nvl[i]), 64'(nwords));
         chk({nm, "_ndone"}, i, 64'(ndn[i]), 64'd1);
         chk({nm, "_vld_ofs"}, i, 64'(vl0[i] - rd0[i]), 64'(i + 2));
         chk({nm, "_done_cyc"}, i, 64'(dnc[i]), 64'(vln[i] + 1));
         chk({nm, "_idle_cyc"}, i, 64'(idc[i]), 64'(dnc[i] + 1));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic bad [3];
      rst_n = 1'b0; inst_en = 1'b0; inst_data = '0; act_req = 1'b0;

      // Scenario 1: base 0x08, n_tp 3, n_tn 2, act_req at row 9
      tbl.push_back(mk(1, 11'h11A, 0, 0, 6'h00, 0, 32'h0, 0, 0));
      for (int k = 0; k < 8; k++) tbl.push_back(mk(0, 11'h0, 0, 0, 6'h00, 0, 32'h0, 1, 0));
      tbl.push_back(mk(0, 11'h0, 1, 0, 6'h00, 0, 32'h0,     1, 0));
      tbl.push_back(mk(0, 11'h0, 1, 1, 6'h08, 0, 32'h0,     1, 0));
      tbl.push_back(mk(0, 11'h0, 1, 1, 6'h09, 0, 32'h0,     1, 0));
      tbl.push_back(mk(0, 11'h0, 1, 1, 6'h0A, 0, 32'h0,     1, 0));
      tbl.push_back(mk(0, 11'h0, 1, 1, 6'h0B, 1, mw(6'h08), 1, 0));
      tbl.push_back(mk(0, 11'h0, 1, 1, 6'h0C, 1, mw(6'h09), 1, 0));
      tbl.push_back(mk(0, 11'h0, 1, 1, 6'h0D, 1, mw(6'h0A), 1, 0));
      tbl.push_back(mk(0, 11'h0, 1, 0, 6'h00, 1, mw(6'h0B), 1, 0));
      tbl.push_back(mk(0, 11'h0, 1, 0, 6'h00, 1, mw(6'h0C), 1, 0));
      tbl.push_back(mk(0, 11'h0, 1, 0, 6'h00, 1, mw(6'h0D), 1, 0));
      tbl.push_back(mk(0, 11'h0, 1, 0, 6'h00, 0, mw(6'h0D), 1, 1));
      for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 11'h0, 1, 0, 6'h00, 0, mw(6'h0D), 0, 0));
      // Scenario 2: base 0x3E, n_tp 3, n_tn 1, address wraps to 0x00
      tbl.push_back(mk(1, 11'h7D9, 1, 0, 6'h00, 0, mw(6'h0D), 0, 0));
      tbl.push_back(mk(0, 11'h0,   1, 0, 6'h00, 0, mw(6'h0D), 1, 0));
      tbl.push_back(mk(0, 11'h0,   1, 1, 6'h3E, 0, mw(6'h0D), 1, 0));
      tbl.push_back(mk(0, 11'h0,   1, 1, 6'h3F, 0, mw(6'h0D), 1, 0));
      tbl.push_back(mk(0, 11'h0,   1, 1, 6'h00, 0, mw(6'h0D), 1, 0));
      tbl.push_back(mk(0, 11'h0,   1, 0, 6'h00, 1, mw(6'h3E), 1, 0));
      tbl.push_back(mk(0, 11'h0,   1, 0, 6'h00, 1, mw(6'h3F), 1, 0));
      tbl.push_back(mk(0, 11'h0,   1, 0, 6'h00, 1, mw(6'h00), 1, 0));
      tbl.push_back(mk(0, 11'h0,   1, 0, 6'h00, 0, mw(6'h00), 1, 1));
      tbl.push_back(mk(0, 11'h0,   0, 0, 6'h00, 0, mw(6'h00), 0, 0));
      tbl.push_back(mk(0, 11'h0,   0, 0, 6'h00, 0, mw(6'h00), 0, 0));
      // Scenario 3: n_tn=0, then n_tp=0 accepted in the cycle busy falls
      tbl.push_back(mk(1, 11'h2B8, 0, 0, 6'h00, 0, mw(6'h00), 0, 0));
      tbl.push_back(mk(0, 11'h0,   0, 0, 6'h00, 0, mw(6'h00), 1, 1));
      tbl.push_back(mk(1, 11'h005, 1, 0, 6'h00, 0, mw(6'h00), 0, 0));
      tbl.push_back(mk(0, 11'h0,   1, 0, 6'h00, 0, mw(6'h00), 1, 1));
      tbl.push_back(mk(0, 11'h0,   1, 0, 6'h00, 0, mw(6'h00), 0, 0));
      tbl.push_back(mk(0, 11'h0,   1, 0, 6'h00, 0, mw(6'h00), 0, 0));

      repeat (3) @(negedge clk_l);
      for (int i = 0; i < 3; i++) chk("reset_outputs", i, outs(i), 64'd0);
      @(posedge clk_l); #1;
      rst_n = 1'b1;

      for (int r = 0; r < tbl.size(); r++) begin
         @(posedge clk_l); #1;
         inst_en   = tbl[r].en;
         inst_data = tbl[r].inst;
         act_req   = tbl[r].req;
         @(negedge clk_l);
         n_vec++;
         if ({m_rd_en[1], m_addr[1], m_vld[1], m_data[1], m_busy[1], m_done[1]} !==
             {tbl[r].rd_en, tbl[r].addr, tbl[r].vld, tbl[r].data, tbl[r].busy, tbl[r].done}) begin
            n_err++;
            $display("FAIL vec[%0d]: got rd_en=%b addr=%h vld=%b data=%h busy=%b done=%b, want rd_en=%b addr=%h vld=%b data=%h busy=%b done=%b",
                     r, m_rd_en[1], m_addr[1], m_vld[1], m_data[1], m_busy[1], m_done[1],
                     tbl[r].rd_en, tbl[r].addr, tbl[r].vld, tbl[r].data, tbl[r].busy, tbl[r].done);
         end
      end
      inst_en = 1'b0;
      act_req = 1'b0;
      repeat (3) @(posedge clk_l);

      // act_req drops mid-burst, second inst while busy, act_req high again after done
      run_seq("req_drop", 11'h21A, 6'h10, 6, 1, 7, 15, 6, 40);
      // Scenario 1 across RD_LAT 1..3
      run_seq("lat_sweep", 11'h11A, 6'h08, 6, 1, 25, 25, -1, 25);

      // Reset on the third STREAM cycle
      @(posedge clk_l); #1;
      inst_en = 1'b1; inst_data = 11'h11A; act_req = 1'b1;
      @(posedge clk_l); #1;
      inst_en = 1'b0;
      repeat (3) @(posedge clk_l);
      #1;
      chk("pre_reset_stream", 1, 64'(m_rd_en[1]), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) chk("async_reset", i, outs(i), 64'd0);
      @(posedge clk_l); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) bad[i] = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk_l);
         for (int i = 0; i < 3; i++)
            if (m_rd_en[i] || m_vld[i] || m_done[i] || m_busy[i]) bad[i] = 1'b1;
      end
      for (int i = 0; i < 3; i++) chk("post_reset_quiet", i, 64'(bad[i]), 64'd0);
      act_req = 1'b0;
      run_seq("post_reset", 11'h11A, 6'h08, 6, 1, 25, 25, -1, 25);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
